// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: decodes {inst, pc} on entry and holds decoded bundles in a DEPTH-entry queue.
// Optional DECODE_STAGE_STATS_EN adds stat_decoded / stat_illegal pop counters.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int SHW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      op_code,
    output logic [3:0]      sub_op_code,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [SHW-1:0]  shift_size,
    output logic [XLEN-1:0] pc,
    output logic            illegal
`ifdef DECODE_STAGE_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]      op;
        logic [3:0]      sub;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [SHW-1:0]  sh;
        logic            ill;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          dec;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic            push, pop;

    logic [4:0]          opc;
    logic [2:0]          f3;
    logic signed [11:0]  imm_i, imm_s;
    logic signed [12:0]  imm_b;
    logic signed [20:0]  imm_j;
    logic signed [31:0]  imm_u;

    assign opc   = in_inst[6:2];
    assign f3    = in_inst[14:12];
    assign imm_i = in_inst[31:20];
    assign imm_s = {in_inst[31:25], in_inst[11:7]};
    assign imm_b = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_j = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_u = {in_inst[31:12], 12'd0};

    // Immediates are sign-extended by casting the signed views up to XLEN.
    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        if (in_inst[1:0] != 2'b11) begin
            dec.ill = 1'b1;
        end else begin
            case (opc)
                5'b01101, 5'b00101: begin
                    dec.imm = XLEN'(imm_u);
                    dec.rd  = in_inst[11:7];
                end
                5'b00100: begin
                    dec.imm = XLEN'(imm_i);
                    dec.rs1 = in_inst[19:15];
                    dec.rd  = in_inst[11:7];
                    dec.sub = {in_inst[30] & (f3 == 3'b101), f3};
                    if (f3 == 3'b001 || f3 == 3'b101)
                        dec.sh = in_inst[20 +: SHW];
                end
                5'b01100: begin
                    dec.rs1 = in_inst[19:15];
                    dec.rs2 = in_inst[24:20];
                    dec.rd  = in_inst[11:7];
                    dec.sub = {in_inst[30], f3};
                end
                5'b00000, 5'b00011, 5'b11100: begin
                    dec.imm = XLEN'(imm_i);
                    dec.rs1 = in_inst[19:15];
                    dec.rd  = in_inst[11:7];
                    dec.sub = {1'b0, f3};
                end
                5'b01000: begin
                    dec.imm = XLEN'(imm_s);
                    dec.rs1 = in_inst[19:15];
                    dec.rs2 = in_inst[24:20];
                    dec.sub = {1'b0, f3};
                end
                5'b11000: begin
                    dec.imm = XLEN'(imm_b);
                    dec.rs1 = in_inst[19:15];
                    dec.rs2 = in_inst[24:20];
                    dec.sub = {1'b0, f3};
                end
                5'b11011: begin
                    dec.imm = XLEN'(imm_j);
                    dec.rd  = in_inst[11:7];
                    dec.sub = 4'b1111;
                end
                5'b11001: begin
                    dec.imm = XLEN'(imm_i);
                    dec.rs1 = in_inst[19:15];
                    dec.rd  = in_inst[11:7];
                end
                default: dec.ill = 1'b1;
            endcase
        end
        if (!dec.ill)
            dec.op = opc;
    end

    assign in_ready  = (count < (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign op_code     = mem[rd_ptr].op;
    assign sub_op_code = mem[rd_ptr].sub;
    assign rs1         = mem[rd_ptr].rs1;
    assign rs2         = mem[rd_ptr].rs2;
    assign rd          = mem[rd_ptr].rd;
    assign imm         = mem[rd_ptr].imm;
    assign shift_size  = mem[rd_ptr].sh;
    assign pc          = mem[rd_ptr].pc;
    assign illegal     = mem[rd_ptr].ill;

`ifdef DECODE_STAGE_STATS_EN
    // Counters track consumption by execute and ignore flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_decoded <= '0;
            stat_illegal <= '0;
        end else if (pop) begin
            stat_decoded <= stat_decoded + 1'b1;
            if (mem[rd_ptr].ill)
                stat_illegal <= stat_illegal + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic against a queue-based model.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int SHW   = $clog2(XLEN);

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc, imm, pc;
    logic [4:0]      op_code, rs1, rs2, rd;
    logic [3:0]      sub_op_code;
    logic [SHW-1:0]  shift_size;
`ifdef DECODE_STAGE_STATS_EN
    logic [31:0]     stat_decoded, stat_illegal;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]      op;
        logic [3:0]      sub;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] imm;
        logic [SHW-1:0]  sh;
        logic            ill;
        logic [XLEN-1:0] pc;
    } exp_t;

    exp_t q[$];
    int   m_dec = 0;
    int   m_ill = 0;
    logic [4:0] legal_ops [10] = '{5'h0D, 5'h05, 5'h04, 5'h0C, 5'h00, 5'h08, 5'h18, 5'h1B, 5'h19, 5'h1C};
    logic [4:0] misc_ops  [2]  = '{5'h03, 5'h1C};

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_code(op_code), .sub_op_code(sub_op_code), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .shift_size(shift_size), .pc(pc), .illegal(illegal)
`ifdef DECODE_STAGE_STATS_EN
        , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Two's-complement interpretation of an n-bit field.
    function automatic longint sx(input longint v, input int n);
        if (v >= (longint'(1) << (n - 1)))
            return v - (longint'(1) << n);
        return v;
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] i, input logic [XLEN-1:0] p);
        exp_t   e;
        int     op, f3;
        longint v;
        e    = '{default: '0};
        e.pc = p;
        op   = int'(i[6:2]);
        f3   = int'(i[14:12]);
        if (i[1:0] != 2'b11) begin
            e.ill = 1'b1;
            return e;
        end
        case (op)
            'h0D, 'h05: begin
                v = sx(longint'(i[31:12]) * 4096, 32);
                e.imm = XLEN'(v); e.rd = i[11:7];
            end
            'h04: begin
                e.imm = XLEN'(sx(longint'(i[31:20]), 12)); e.rs1 = i[19:15]; e.rd = i[11:7];
                e.sub = 4'(f3 + ((f3 == 5 && i[30]) ? 8 : 0));
                if (f3 == 1 || f3 == 5) e.sh = SHW'(int'(i[31:20]) % XLEN);
            end
            'h0C: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
                e.sub = 4'(f3 + (i[30] ? 8 : 0));
            end
            'h00, 'h03, 'h1C, 'h19: begin
                e.imm = XLEN'(sx(longint'(i[31:20]), 12)); e.rs1 = i[19:15]; e.rd = i[11:7];
                e.sub = (op == 'h19) ? 4'd0 : 4'(f3);
            end
            'h08: begin
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                e.imm = XLEN'(sx(v, 12)); e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.sub = 4'(f3);
            end
            'h18: begin
                v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                e.imm = XLEN'(sx(v, 13)); e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.sub = 4'(f3);
            end
            'h1B: begin
                v = longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                e.imm = XLEN'(sx(v, 21)); e.rd = i[11:7]; e.sub = 4'hF;
            end
            default: e.ill = 1'b1;
        endcase
        if (!e.ill) e.op = 5'(op);
        return e;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       ;
            1:       r[6:2] = misc_ops[$urandom_range(0, 1)];
            default: r[6:2] = legal_ops[$urandom_range(0, 9)];
        endcase
        if ($urandom_range(0, 9) != 0) r[1:0] = 2'b11;
        return r;
    endfunction

    // One clock: compare DUT against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic do_push, do_pop;
        exp_t h;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            chk("op_code", 64'(op_code), 64'(h.op));
            chk("sub_op_code", 64'(sub_op_code), 64'(h.sub));
            chk("rs1", 64'(rs1), 64'(h.rs1));
            chk("rs2", 64'(rs2), 64'(h.rs2));
            chk("rd", 64'(rd), 64'(h.rd));
            chk("imm", 64'(imm), 64'(h.imm));
            chk("shift_size", 64'(shift_size), 64'(h.sh));
            chk("pc", 64'(pc), 64'(h.pc));
            chk("illegal", 64'(illegal), 64'(h.ill));
        end
`ifdef DECODE_STAGE_STATS_EN
        chk("stat_decoded", 64'(stat_decoded), 64'(m_dec));
        chk("stat_illegal", 64'(stat_illegal), 64'(m_ill));
`endif
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = out_ready && (q.size() != 0);
        @(posedge clk);
        if (do_pop) begin
            m_dec++;
            if (q[0].ill) m_ill++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(ref_dec(in_inst, in_pc));
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0; in_pc = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst op_code", 64'(op_code), 64'd0);
        chk("rst imm", 64'(imm), 64'd0);
        chk("rst pc", 64'(pc), 64'd0);
        chk("rst illegal", 64'(illegal), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);

        // ADDI x1,x0,-1
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h100;
        cycle();
        in_valid = 1'b0;
        chk("addi out_valid", 64'(out_valid), 64'd1);
        chk("addi op_code", 64'(op_code), 64'h04);
        chk("addi rd", 64'(rd), 64'd1);
        chk("addi rs1", 64'(rs1), 64'd0);
        chk("addi imm", 64'(imm), 64'hFFFFFFFF);
        chk("addi sub", 64'(sub_op_code), 64'd0);
        chk("addi shift", 64'(shift_size), 64'd0);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // SRAI x2,x1,2
        in_valid = 1'b1; in_inst = 32'h4020D113; in_pc = 32'h104;
        cycle();
        in_valid = 1'b0;
        chk("srai sub", 64'(sub_op_code), 64'hD);
        chk("srai shift", 64'(shift_size), 64'd2);
        chk("srai imm", 64'(imm), 64'h402);
        chk("srai rd", 64'(rd), 64'd2);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // BEQ x0,x0,-4
        in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 32'h108;
        cycle();
        in_valid = 1'b0;
        chk("beq imm", 64'(imm), 64'hFFFFFFFC);
        chk("beq rs1", 64'(rs1), 64'd0);
        chk("beq rs2", 64'(rs2), 64'd0);
        chk("beq rd", 64'(rd), 64'd0);
        chk("beq sub", 64'(sub_op_code), 64'd0);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // Backpressure: third push waits until a slot frees
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h0;
        cycle();
        in_pc = 32'h4; cycle();
        chk("bp full in_ready", 64'(in_ready), 64'd0);
        in_pc = 32'h8; cycle();
        out_ready = 1'b1;
        chk("bp head0 pc", 64'(pc), 64'h0);
        cycle();
        chk("bp head1 pc", 64'(pc), 64'h4);
        chk("bp in_ready after pop", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        chk("bp head2 pc", 64'(pc), 64'h8);
        cycle();
        chk("bp drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Illegal all-zero word
        in_valid = 1'b1; in_inst = 32'h0; in_pc = 32'h200;
        cycle();
        in_valid = 1'b0;
        chk("ill illegal", 64'(illegal), 64'd1);
        chk("ill op_code", 64'(op_code), 64'd0);
        chk("ill pc", 64'(pc), 64'h200);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
`ifdef DECODE_STAGE_STATS_EN
        chk("stat_illegal one", 64'(stat_illegal), 64'd1);
`endif

        // Flush with a concurrent push
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h10; cycle();
        in_pc = 32'h14; cycle();
        flush = 1'b1; in_pc = 32'h18; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush in_ready", 64'(in_ready), 64'd1);

        // Async reset with two entries queued
        in_valid = 1'b1; in_pc = 32'h20; cycle();
        in_pc = 32'h24; cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset out_valid", 64'(out_valid), 64'd0);
        q.delete(); m_dec = 0; m_ill = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("areset in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_inst   = rnd_inst();
            in_pc     = $urandom;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
